// File: rtl/axi2apb_pkg.sv
// axi2apb_pkg: shared state encoding, AXI response/burst codes and the
// worst-of response merge used by the AXI3-to-APB4 bridge.
package axi2apb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_RDATA, S_BRESP} state_e;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a == RESP_DECERR || b == RESP_DECERR) ? RESP_DECERR :
               (a == RESP_SLVERR || b == RESP_SLVERR) ? RESP_SLVERR :
               (a == RESP_EXOKAY && b == RESP_EXOKAY) ? RESP_EXOKAY : RESP_OKAY;
    endfunction
endpackage

// File: rtl/axi2apb_bridge_mp_decoder.sv
// apb_slv_decoder: maps an address onto a one-hot APB slave select;
// slave i owns the window BASE_ADDR + i*2**SLV_AW.
module apb_slv_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLV-1:0]    psel_o,
    output logic                  hit_o
);
    logic [ADDR_WIDTH-1:0] w_idx;
    assign w_idx = (addr_i - BASE_ADDR) >> SLV_AW;
    assign hit_o = (addr_i >= BASE_ADDR) && (w_idx < ADDR_WIDTH'(NUM_SLV));
    for (genvar i = 0; i < NUM_SLV; i++) begin : g_sel
        assign psel_o[i] = hit_o && (w_idx == ADDR_WIDTH'(i));
    end
endmodule

// File: rtl/axi2apb_bridge_mp.sv
// axi2apb_bridge_mp: AXI3 slave to APB4 master bridge with one APB transfer in
// flight, fair read/write arbitration and per-beat slave decode.
module axi2apb_bridge_mp
    import axi2apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0001_0000,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [3:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [3:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    output logic                    pwrite_o,
    output logic                    penable_o,
    output logic [NUM_SLV-1:0]      psel_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e r_state, w_next, w_after;
    logic r_wr, r_prio_wr;
    logic [ID_WIDTH-1:0] r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0] r_len, r_cnt;
    logic [2:0] r_size;
    logic [1:0] r_burst, r_bresp, r_rresp, w_beat_resp;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_W-1:0] r_wstrb;
    logic [TW-1:0] r_tmo;
    logic [NUM_SLV-1:0] w_psel;
    logic w_hit, w_ok, w_last, w_tmo, w_gnt_wr, w_gnt_rd, w_beat_done, w_adv, w_unused;

    apb_slv_decoder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_SLV(NUM_SLV),
        .SLV_AW(SLV_AW),
        .BASE_ADDR(BASE_ADDR)
    ) u_dec (
        .addr_i(r_addr),
        .psel_o(w_psel),
        .hit_o(w_hit)
    );

    // Burst length comes from awlen alone, so wlast carries no information here.
    assign w_unused = wlast_i;
    assign w_gnt_wr = !rst && awvalid_i && (!arvalid_i || r_prio_wr);
    assign w_gnt_rd = !rst && arvalid_i && !w_gnt_wr;
    assign w_ok = w_hit && r_burst != BURST_WRAP && r_burst != 2'b11 &&
                  !(r_burst == BURST_INCR && r_size > MAX_SIZE);
    assign w_last = r_cnt == r_len;
    assign w_tmo = !pready_i && r_tmo == TW'(TIMEOUT - 1);
    assign w_after = r_wr ? (w_last ? S_BRESP : S_WDATA) : S_RDATA;
    assign w_adv = (w_beat_done && r_wr && !w_last) || (r_state == S_RDATA && rready_i && !w_last);

    always_comb begin
        w_next = r_state;
        awready_o = 1'b0;
        arready_o = 1'b0;
        wready_o = 1'b0;
        w_beat_done = 1'b0;
        w_beat_resp = RESP_OKAY;
        case (r_state)
            S_IDLE: begin
                awready_o = w_gnt_wr;
                arready_o = w_gnt_rd;
                w_next = w_gnt_wr ? S_WDATA : w_gnt_rd ? S_SETUP : S_IDLE;
            end
            S_WDATA: begin
                wready_o = 1'b1;
                w_next = wvalid_i ? S_SETUP : S_WDATA;
            end
            S_SETUP: begin
                w_beat_done = !w_ok;
                w_beat_resp = w_hit ? RESP_SLVERR : RESP_DECERR;
                w_next = w_ok ? S_ACCESS : w_after;
            end
            S_ACCESS: begin
                w_beat_done = pready_i || w_tmo;
                w_beat_resp = (pslverr_i || !pready_i) ? RESP_SLVERR : RESP_OKAY;
                w_next = w_beat_done ? w_after : S_ACCESS;
            end
            S_RDATA: w_next = rready_i ? (w_last ? S_IDLE : S_SETUP) : S_RDATA;
            S_BRESP: w_next = bready_i ? S_IDLE : S_BRESP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= 1'b0;
            r_prio_wr <= 1'b1;
            r_id <= '0;
            r_addr <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_size <= '0;
            r_burst <= '0;
            r_bresp <= RESP_OKAY;
            r_rresp <= RESP_OKAY;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_tmo <= '0;
        end else begin
            if (awready_o) begin
                r_wr <= 1'b1;
                r_prio_wr <= 1'b0;
                r_id <= awid_i;
                r_addr <= awaddr_i;
                r_len <= awlen_i;
                r_size <= awsize_i;
                r_burst <= awburst_i;
                r_cnt <= '0;
                r_bresp <= RESP_OKAY;
            end else if (arready_o) begin
                r_wr <= 1'b0;
                r_prio_wr <= 1'b1;
                r_id <= arid_i;
                r_addr <= araddr_i;
                r_len <= arlen_i;
                r_size <= arsize_i;
                r_burst <= arburst_i;
                r_cnt <= '0;
            end
            if (wready_o && wvalid_i) begin
                r_wdata <= wdata_i;
                r_wstrb <= wstrb_i;
            end
            r_tmo <= (r_state == S_ACCESS && !w_beat_done) ? r_tmo + 1'b1 : '0;
            if (w_beat_done) begin
                r_bresp <= resp_max(r_bresp, w_beat_resp);
                r_rresp <= w_beat_resp;
                r_rdata <= (r_state == S_ACCESS && pready_i) ? prdata_i : '0;
            end
            if (w_adv) begin
                r_cnt <= r_cnt + 1'b1;
                r_addr <= (r_burst == BURST_FIXED) ? r_addr : r_addr + (ADDR_WIDTH'(1) << r_size);
            end
        end
    end

    assign bvalid_o = r_state == S_BRESP;
    assign bid_o = r_id;
    assign bresp_o = r_bresp;
    assign rvalid_o = r_state == S_RDATA;
    assign rid_o = r_id;
    assign rdata_o = r_rdata;
    assign rresp_o = r_rresp;
    assign rlast_o = rvalid_o && w_last;
    assign psel_o = ((r_state == S_SETUP || r_state == S_ACCESS) && w_ok) ? w_psel : '0;
    assign penable_o = r_state == S_ACCESS;
    assign paddr_o = r_addr;
    assign pwrite_o = r_wr;
    assign pwdata_o = r_wdata;
    assign pstrb_o = r_wr ? r_wstrb : '0;
endmodule

// File: tb/tb_axi2apb_bridge_mp.sv
// tb_axi2apb_bridge_mp: directed bench for the AXI3-to-APB4 bridge covering
// latency, bursts, decode miss, timeout, arbitration, rready stall and reset.
module tb_axi2apb_bridge_mp;
    import axi2apb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] awid_i = '0, arid_i = '0, awlen_i = '0, arlen_i = '0, wstrb_i = '0;
    logic [31:0] awaddr_i = '0, araddr_i = '0, wdata_i = '0, prdata_i = '0;
    logic [2:0] awsize_i = '0, arsize_i = '0;
    logic [1:0] awburst_i = '0, arburst_i = '0;
    logic awvalid_i = 1'b0, arvalid_i = 1'b0, wlast_i = 1'b0, wvalid_i = 1'b0;
    logic bready_i = 1'b0, rready_i = 1'b0, pready_i = 1'b0, pslverr_i = 1'b0;
    logic awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o, pwrite_o, penable_o;
    logic [3:0] bid_o, rid_o, pstrb_o, psel_o;
    logic [1:0] bresp_o, rresp_o;
    logic [31:0] rdata_o, paddr_o, pwdata_o;
    logic [15:0] w_ctrl;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int sel_cnt = 0;
    logic [31:0] last_paddr = '0, last_pwdata = '0;
    logic [3:0] last_pstrb = '0;

    axi2apb_bridge_mp dut (
        .clk(clk), .rst(rst),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i),
        .wready_o(wready_o), .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o),
        .bready_i(bready_i), .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i),
        .arsize_i(arsize_i), .arburst_i(arburst_i), .arvalid_i(arvalid_i),
        .arready_o(arready_o), .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pwrite_o(pwrite_o), .penable_o(penable_o),
        .psel_o(psel_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk = ~clk;

    assign w_ctrl = {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, rlast_o,
                     penable_o, pwrite_o, psel_o, bresp_o, rresp_o};

    // APB-side monitor: counts ACCESS/select cycles and records the last completed transfer.
    always @(negedge clk) begin
        if (penable_o) acc_cnt++;
        if (|psel_o) sel_cnt++;
        if (penable_o && pready_i) begin
            last_paddr = paddr_o;
            last_pwdata = pwdata_o;
            last_pstrb = pstrb_o;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic aw_issue(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [2:0] s);
        awid_i = 4'h7;
        awaddr_i = a;
        awlen_i = l;
        awburst_i = b;
        awsize_i = s;
        awvalid_i = 1'b1;
        #1 chk("awready", awready_o, 1);
        @(negedge clk);
        awvalid_i = 1'b0;
    endtask

    task automatic ar_issue(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b, input logic [2:0] s);
        arid_i = 4'h5;
        araddr_i = a;
        arlen_i = l;
        arburst_i = b;
        arsize_i = s;
        arvalid_i = 1'b1;
        #1 chk("arready", arready_o, 1);
        @(negedge clk);
        arvalid_i = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] st);
        int n = 0;
        while (!wready_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wready_wait", wready_o, 1);
        wdata_i = d;
        wstrb_i = st;
        wvalid_i = 1'b1;
        @(negedge clk);
        wvalid_i = 1'b0;
    endtask

    task automatic b_wait();
        int n = 0;
        while (!bvalid_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid_wait", bvalid_o, 1);
    endtask

    task automatic b_ack();
        bready_i = 1'b1;
        @(negedge clk);
        bready_i = 1'b0;
    endtask

    task automatic r_wait(output int n);
        n = 0;
        while (!rvalid_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("rvalid_wait", rvalid_o, 1);
    endtask

    task automatic r_ack();
        rready_i = 1'b1;
        @(negedge clk);
        rready_i = 1'b0;
    endtask

    initial begin
        int n, a0, s0, bc;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", w_ctrl, 0);
        chk("rst_data", {rdata_o, paddr_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ctrl", w_ctrl, 0);

        // 1: single write, exact cycle latency
        pready_i = 1'b1;
        awid_i = 4'h3;
        awaddr_i = 32'h0001_2004;
        awlen_i = 4'd0;
        awsize_i = 3'd2;
        awburst_i = BURST_INCR;
        awvalid_i = 1'b1;
        wdata_i = 32'hDEAD_BEEF;
        wstrb_i = 4'hF;
        wlast_i = 1'b1;
        wvalid_i = 1'b1;
        #1 chk("t1_awready", awready_o, 1);
        @(negedge clk);
        awvalid_i = 1'b0;
        chk("t1_wready", wready_o, 1);
        @(negedge clk);
        wvalid_i = 1'b0;
        chk("t1_setup", {psel_o, penable_o, pwrite_o, paddr_o}, {4'b0100, 1'b0, 1'b1, 32'h0001_2004});
        @(negedge clk);
        chk("t1_access", {psel_o, penable_o, pstrb_o, pwdata_o}, {4'b0100, 1'b1, 4'hF, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("t1_bresp", {bvalid_o, bid_o, bresp_o, psel_o}, {1'b1, 4'h3, RESP_OKAY, 4'b0000});
        b_ack();
        chk("t1_bdone", bvalid_o, 0);

        // 2: INCR read burst of 4
        ar_issue(32'h0001_0000, 4'd3, BURST_INCR, 3'd2);
        for (int k = 0; k < 4; k++) begin
            prdata_i = 32'h10 + k;
            r_wait(n);
            chk("t2_lat", n, 2);
            chk("t2_beat", {rlast_o, rid_o, rresp_o, rdata_o}, {k == 3, 4'h5, RESP_OKAY, 32'h10 + k});
            chk("t2_paddr", last_paddr, 32'h0001_0000 + 4 * k);
            r_ack();
        end

        // 3: decode miss on write and read
        s0 = sel_cnt;
        aw_issue(32'h0000_8000, 4'd1, BURST_INCR, 3'd2);
        w_beat(32'h1, 4'hF);
        w_beat(32'h2, 4'hF);
        b_wait();
        chk("t3_bresp", bresp_o, RESP_DECERR);
        b_ack();
        ar_issue(32'h0000_8000, 4'd1, BURST_INCR, 3'd2);
        for (int k = 0; k < 2; k++) begin
            r_wait(n);
            chk("t3_rbeat", {rlast_o, rresp_o, rdata_o}, {k == 1, RESP_DECERR, 32'h0});
            r_ack();
        end
        chk("t3_nosel", sel_cnt - s0, 0);

        // 4: PREADY timeout
        pready_i = 1'b0;
        ar_issue(32'h0001_3000, 4'd0, BURST_INCR, 3'd2);
        a0 = acc_cnt;
        r_wait(n);
        chk("t4_access_cycles", acc_cnt - a0, 255);
        chk("t4_rbeat", {rlast_o, rresp_o, rdata_o, psel_o}, {1'b1, RESP_SLVERR, 32'h0, 4'b0000});
        r_ack();
        pready_i = 1'b1;
        prdata_i = 32'h0000_00A5;
        ar_issue(32'h0001_3000, 4'd0, BURST_INCR, 3'd2);
        r_wait(n);
        chk("t4_next", {rresp_o, rdata_o}, {RESP_OKAY, 32'h0000_00A5});
        r_ack();

        // 5: contention twice, then rready stall
        awid_i = 4'h1;
        awaddr_i = 32'h0001_1000;
        awlen_i = 4'd0;
        awvalid_i = 1'b1;
        arid_i = 4'h2;
        araddr_i = 32'h0001_3008;
        arlen_i = 4'd0;
        arvalid_i = 1'b1;
        #1 chk("t5_gnt1", {awready_o, arready_o}, 2'b10);
        @(negedge clk);
        awvalid_i = 1'b0;
        w_beat(32'h5555_0000, 4'h3);
        b_wait();
        chk("t5_b1", {bid_o, bresp_o}, {4'h1, RESP_OKAY});
        chk("t5_apbw", {last_pstrb, last_pwdata}, {4'h3, 32'h5555_0000});
        b_ack();
        awaddr_i = 32'h0001_1004;
        awvalid_i = 1'b1;
        #1 chk("t5_gnt2", {awready_o, arready_o}, 2'b01);
        @(negedge clk);
        arvalid_i = 1'b0;
        prdata_i = 32'hCAFE_0001;
        r_wait(n);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold", {rvalid_o, rid_o, rdata_o}, {1'b1, 4'h2, 32'hCAFE_0001});
            prdata_i = 32'h0;
            @(negedge clk);
        end
        r_ack();
        chk("t5_gnt3", {awready_o, arready_o}, 2'b10);
        @(negedge clk);
        awvalid_i = 1'b0;
        w_beat(32'h6666_0000, 4'hF);
        b_wait();
        chk("t5_b2", {bid_o, bresp_o, last_paddr}, {4'h1, RESP_OKAY, 32'h0001_1004});
        b_ack();

        // 6: reset during the third beat of an 8-beat write
        aw_issue(32'h0001_0000, 4'd7, BURST_INCR, 3'd2);
        w_beat(32'hA0, 4'hF);
        w_beat(32'hA1, 4'hF);
        w_beat(32'hA2, 4'hF);
        chk("t6_mid", {psel_o, paddr_o}, {4'b0001, 32'h0001_0008});
        rst = 1'b1;
        #1 chk("t6_rst_ctrl", w_ctrl, 0);
        chk("t6_rst_addr", paddr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        bc = 0;
        repeat (5) begin
            @(negedge clk);
            if (bvalid_o) bc++;
        end
        chk("t6_no_b", bc, 0);
        aw_issue(32'h0001_3000, 4'd0, BURST_INCR, 3'd2);
        w_beat(32'h7777_0000, 4'hF);
        b_wait();
        chk("t6_after", {bresp_o, last_paddr}, {RESP_OKAY, 32'h0001_3000});
        b_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
